// File: rtl/bp_pkg.sv
// Shared branch-predictor types: BHT counter encodings, BTB entry layout and
// the 2-bit saturating counter update.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_t;

  // BTB entry layout for the default geometry (32-bit PC, 64 entries).
  localparam int BP_WIDTH = 32;
  localparam int BP_IDX   = 6;

  typedef struct packed {
    logic                         valid;
    logic [BP_WIDTH-BP_IDX-3:0]   tag;
    logic [BP_WIDTH-1:0]          target;
  } btb_entry_t;

  function automatic bht_state_t sat_update(input bht_state_t cur, input logic taken);
    bht_state_t nxt;
    case (cur)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = WNT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor.sv
// Direct-mapped BHT (2-bit counters) plus BTB with one combinational lookup
// port and one synchronous update port.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int BHT_ENTRIES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rd_pc,
  output logic             bp_taken,
  output logic [WIDTH-1:0] bp_target,
  input  logic             upd_en,
  input  logic [WIDTH-1:0] upd_pc,
  input  logic             upd_taken,
  input  logic [WIDTH-1:0] upd_target
);

  localparam int IDX   = $clog2(BHT_ENTRIES);
  localparam int TAG_W = WIDTH - IDX - 2;

  bht_state_t             bht_q    [BHT_ENTRIES];
  bht_state_t             bht_d    [BHT_ENTRIES];
  logic [BHT_ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q    [BHT_ENTRIES];
  logic [TAG_W-1:0]       tag_d    [BHT_ENTRIES];
  logic [WIDTH-1:0]       target_q [BHT_ENTRIES];
  logic [WIDTH-1:0]       target_d [BHT_ENTRIES];

  logic [IDX-1:0]   rd_idx, upd_idx;
  logic [TAG_W-1:0] rd_tag, upd_tag;
  logic             unused_pc_bits;

  assign rd_idx  = rd_pc[IDX+1:2];
  assign rd_tag  = rd_pc[WIDTH-1:IDX+2];
  assign upd_idx = upd_pc[IDX+1:2];
  assign upd_tag = upd_pc[WIDTH-1:IDX+2];
  assign unused_pc_bits = ^{rd_pc[1:0], upd_pc[1:0]};

  // Lookup reads the registered arrays, so a same-cycle update is seen next cycle.
  assign bp_taken  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag) && bht_q[rd_idx][1];
  assign bp_target = target_q[rd_idx];

  always_comb begin
    bht_d    = bht_q;
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (upd_en) begin
      bht_d[upd_idx] = sat_update(bht_q[upd_idx], upd_taken);
      if (upd_taken) begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= WNT;
      end
    end else begin
      valid_q <= valid_d;
      bht_q   <= bht_d;
    end
  end

  // Tag/target are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, next-PC selection and branch prediction feeding
// the F/D pipeline register.
module fetch_unit
  import bp_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               BHT_ENTRIES = 64,
  parameter logic [WIDTH-1:0] RESET_PC    = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             div_stall,
  input  logic             cache_stall,
  input  logic             redirect_e,
  input  logic [WIDTH-1:0] redirect_pc_e,
  input  logic             upd_valid_e,
  input  logic [WIDTH-1:0] upd_pc_e,
  input  logic             upd_taken_e,
  input  logic [WIDTH-1:0] upd_target_e,
  output logic [WIDTH-1:0] imem_addr,
  output logic [WIDTH-1:0] pc_f,
  output logic [WIDTH-1:0] pc_plus4_f,
  output logic             bp_f
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pred_target, pred_pc;
  logic             pred_taken;
  logic             freeze;

  assign freeze = div_stall || cache_stall;

  branch_predictor #(
    .WIDTH       (WIDTH),
    .BHT_ENTRIES (BHT_ENTRIES)
  ) u_bp (
    .clk        (clk),
    .rst        (rst),
    .rd_pc      (pc_q),
    .bp_taken   (pred_taken),
    .bp_target  (pred_target),
    .upd_en     (upd_valid_e && !freeze),
    .upd_pc     (upd_pc_e),
    .upd_taken  (upd_taken_e),
    .upd_target (upd_target_e)
  );

  assign pc_plus4_f = pc_q + WIDTH'(4);
  assign pred_pc    = pred_taken ? pred_target : pc_plus4_f;

  // A redirect held by E across a freeze lands on the first unfrozen edge.
  always_comb begin
    pc_d = pc_q;
    if (freeze) begin
      pc_d = pc_q;
    end else if (redirect_e) begin
      pc_d = redirect_pc_e;
    end else if (!stall) begin
      pc_d = pred_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc_f      = pc_q;
  assign bp_f      = pred_taken;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_fetch_unit;

  localparam int unsigned RST_PC = 32'h0000_0000;
  localparam int unsigned N      = 64;

  logic        clk = 1'b0;
  logic        rst, stall, div_stall, cache_stall, redirect_e;
  logic [31:0] redirect_pc_e, upd_pc_e, upd_target_e;
  logic        upd_valid_e, upd_taken_e;
  logic [31:0] imem_addr, pc_f, pc_plus4_f;
  logic        bp_f;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  int unsigned m_pc;
  int          m_ctr [N];
  bit          m_val [N];
  int unsigned m_tag [N];
  int unsigned m_tgt [N];

  fetch_unit #(.WIDTH(32), .BHT_ENTRIES(64), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .div_stall     (div_stall),
    .cache_stall   (cache_stall),
    .redirect_e    (redirect_e),
    .redirect_pc_e (redirect_pc_e),
    .upd_valid_e   (upd_valid_e),
    .upd_pc_e      (upd_pc_e),
    .upd_taken_e   (upd_taken_e),
    .upd_target_e  (upd_target_e),
    .imem_addr     (imem_addr),
    .pc_f          (pc_f),
    .pc_plus4_f    (pc_plus4_f),
    .bp_f          (bp_f)
  );

  always #5 clk = ~clk;

  function automatic int unsigned m_idx(input int unsigned pc);
    return (pc / 4) % N;
  endfunction

  function automatic bit m_pred(input int unsigned pc);
    int unsigned i;
    i = m_idx(pc);
    return m_val[i] && (m_tag[i] == pc / 256) && (m_ctr[i] >= 2);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model, clock, then compare.
  task automatic cycle(input bit r, input bit st, input bit dv, input bit cc,
                       input bit rd, input int unsigned rpc,
                       input bit uv, input int unsigned upc, input bit ut,
                       input int unsigned utg);
    bit          fr;
    int unsigned nxt, i;
    rst = r; stall = st; div_stall = dv; cache_stall = cc;
    redirect_e = rd; redirect_pc_e = rpc;
    upd_valid_e = uv; upd_pc_e = upc; upd_taken_e = ut; upd_target_e = utg;
    if (r) begin
      m_pc = RST_PC;
      for (int k = 0; k < N; k++) begin
        m_ctr[k] = 1;
        m_val[k] = 0;
      end
    end else begin
      fr  = dv || cc;
      nxt = m_pred(m_pc) ? m_tgt[m_idx(m_pc)] : m_pc + 4;
      if (!fr) begin
        if (rd) m_pc = rpc;
        else if (!st) m_pc = nxt;
        if (uv) begin
          i = m_idx(upc);
          m_ctr[i] = ut ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                        : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
          if (ut) begin
            m_val[i] = 1;
            m_tag[i] = upc / 256;
            m_tgt[i] = utg;
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("pc_f", pc_f, m_pc);
    check("imem_addr", imem_addr, m_pc);
    check("pc_plus4_f", pc_plus4_f, m_pc + 4);
    check("bp_f", {31'b0, bp_f}, {31'b0, m_pred(m_pc)});
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic redir(input int unsigned pc);
    cycle(0, 0, 0, 0, 1, pc, 0, 0, 0, 0);
  endtask

  task automatic train(input int unsigned pc, input bit t, input int unsigned tgt);
    cycle(0, 0, 0, 0, 0, 0, 1, pc, t, tgt);
  endtask

  initial begin
    int unsigned rpc, upc;
    {rst, stall, div_stall, cache_stall, redirect_e, upd_valid_e, upd_taken_e} = '0;
    {redirect_pc_e, upd_pc_e, upd_target_e} = '0;
    @(negedge clk);

    // Reset and free run
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("lit_reset_pc", pc_f, 32'h0);
    check("lit_reset_p4", pc_plus4_f, 32'h4);
    check("lit_reset_bp", {31'b0, bp_f}, 32'h0);
    repeat (3) idle();
    check("lit_run_pc", pc_f, 32'hC);
    idle();

    // Stall, div_stall, cache_stall hold
    repeat (3) cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("lit_stall_hold", pc_f, 32'h10);
    idle();
    check("lit_stall_rel", pc_f, 32'h14);
    repeat (3) cycle(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("lit_div_hold", pc_f, 32'h14);
    idle();
    repeat (3) cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    check("lit_cache_hold", pc_f, 32'h18);
    idle();
    check("lit_cache_rel", pc_f, 32'h1C);

    // Training and untraining
    train(32'h20, 1, 32'h80);
    check("lit_train_pc", pc_f, 32'h20);
    check("lit_train_bp", {31'b0, bp_f}, 32'h1);
    idle();
    check("lit_train_tgt", pc_f, 32'h80);
    train(32'h20, 0, 0);
    train(32'h20, 0, 0);
    redir(32'h20);
    check("lit_untrain_bp", {31'b0, bp_f}, 32'h0);
    idle();
    check("lit_untrain_pc", pc_f, 32'h24);

    // Saturation
    repeat (5) train(32'h40, 1, 32'h200);
    train(32'h40, 0, 0);
    idle();
    check("lit_sat_pc", pc_f, 32'h40);
    check("lit_sat_bp", {31'b0, bp_f}, 32'h1);
    idle();
    check("lit_sat_tgt", pc_f, 32'h200);

    // Priority: redirect over stall; redirect and update deferred by freeze
    cycle(0, 1, 0, 0, 1, 32'h100, 0, 0, 0, 0);
    check("lit_redir_stall", pc_f, 32'h100);
    idle();
    repeat (2) begin
      cycle(0, 0, 0, 1, 1, 32'h100, 1, 32'h104, 1, 32'h400);
      check("lit_frz_hold", pc_f, 32'h104);
      check("lit_frz_noupd", {31'b0, bp_f}, 32'h0);
    end
    cycle(0, 0, 0, 0, 1, 32'h100, 1, 32'h104, 1, 32'h400);
    check("lit_frz_rel", pc_f, 32'h100);
    redir(32'h104);
    check("lit_frz_upd", {31'b0, bp_f}, 32'h1);
    idle();
    check("lit_frz_tgt", pc_f, 32'h400);

    // Aliasing and mid-run reset
    train(32'h20, 1, 32'h80);
    train(32'h20, 1, 32'h80);
    redir(32'h120);
    check("lit_alias_bp", {31'b0, bp_f}, 32'h0);
    redir(32'h20);
    check("lit_alias_hit", {31'b0, bp_f}, 32'h1);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("lit_mrst_pc", pc_f, 32'h0);
    redir(32'h20);
    check("lit_mrst_bp", {31'b0, bp_f}, 32'h0);

    // Wraparound of pc + 4
    redir(32'hFFFF_FFFC);
    check("lit_wrap_p4", pc_plus4_f, 32'h0);
    idle();
    check("lit_wrap_pc", pc_f, 32'h0);

    // Randomized traffic over a small address window so indices alias
    for (int n = 0; n < 3000; n++) begin
      rpc = {$urandom_range(0, 255), 2'b00};
      upc = {$urandom_range(0, 255), 2'b00};
      cycle($urandom_range(0, 99) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0, rpc,
            $urandom_range(0, 2) == 0, upc,
            $urandom_range(0, 1) == 1,
            {$urandom_range(0, 255), 2'b00});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Fetch stage producer for the F/D pipeline register. It owns the PC register, drives the instruction-memory address, and supplies pc_f, pc_plus4_f and bp_f to the F/D register. A direct-mapped BHT (2-bit saturating counters) with a BTB predicts taken branches and jumps. Predictor state is trained, and the PC is redirected, from branch-resolution results returned by the execute stage.

Parameters:
WIDTH, 32, datapath/address width
BHT_ENTRIES, 64, number of BHT/BTB entries; power of two, at least 2
RESET_PC, 32'h0000_0000, PC value after reset

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
stall  in  1  hazard-unit load-use stall; freezes F only
div_stall  in  1  divider busy; freezes whole pipeline
cache_stall  in  1  cache miss; freezes whole pipeline
redirect_e  in  1  execute-stage mispredict; load redirect_pc_e
redirect_pc_e  in  WIDTH  corrected PC
upd_valid_e  in  1  a branch or jump resolved in E this cycle
upd_pc_e  in  WIDTH  PC of the resolved instruction
upd_taken_e  in  1  actual outcome
upd_target_e  in  WIDTH  actual target
imem_addr  out  WIDTH  instruction-memory address; equals pc_f
pc_f  out  WIDTH  current fetch PC
pc_plus4_f  out  WIDTH  pc_f + 4
bp_f  out  1  prediction for pc_f: 1 = predicted taken

Behaviour:
- Index: idx = pc[IDX+1:2], where IDX = log2(BHT_ENTRIES). Tag = pc[WIDTH-1:IDX+2].
- BTB entry holds valid, tag and target.
- Prediction is combinational from pc_f:
  - hit = valid[idx] && tag match.
  - bp_f = hit && bht[idx][1].
  - pred_pc = bp_f ? btb_target[idx] : pc_f + 4.
- pc_plus4_f is modulo 2^WIDTH; wrap from 0xFFFF_FFFC gives 0x0000_0000.
- Freeze = div_stall || cache_stall.
- PC next-state priority, evaluated on each rising clk edge:
  1. rst: pc ← RESET_PC.
  2. freeze: hold. A redirect_e asserted during freeze is not lost; E holds it asserted and it applies on the first unfrozen edge.
  3. redirect_e: pc ← redirect_pc_e. This wins over stall.
  4. stall: hold.
  5. otherwise: pc ← pred_pc.
- Predictor update, applied only when upd_valid_e && !freeze and not in reset:
  - bht[u] saturating: increment if upd_taken_e, else decrement. Range 00..11; 11+taken stays 11, 00+not-taken stays 00.
  - If upd_taken_e: btb[u] ← {valid=1, tag(upd_pc_e), upd_target_e}.
  - If not taken: BTB entry unchanged.
- Updates are independent of redirect_e; both can occur in the same cycle.
- Read/write collision: when a prediction read and an update hit the same index in one cycle, the read sees the old value and the update is visible from the next cycle.
- Reset, including mid-operation: pc ← RESET_PC; all BTB valid ← 0; all BHT counters ← 2'b01 (weakly not-taken). Outputs on the first cycle after reset: pc_f = imem_addr = RESET_PC, pc_plus4_f = RESET_PC+4, bp_f = 0.
- Ownership of control: F/D flush is generated by the hazard unit, not by this block. This block never stalls itself.
- Pipeline role: no added latency; the fetch PC is registered once, and outputs are combinational from that register and the arrays.

Decomposition:
- Shared package bp_pkg holds:
  - BHT state encodings: SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - The btb_entry_t struct {valid, tag, target}.
  - A sat_update function.
- One natural sub-module, branch_predictor. It holds the BHT and BTB arrays, the prediction lookup port and the update port.
- fetch_unit instantiates branch_predictor and owns the PC register and next-PC mux.

Test Plan:
1. Reset, then 4 free-running cycles → pc_f = 0x0, 0x4, 0x8, 0xC; bp_f = 0 throughout; pc_plus4_f = pc_f + 4.
2. Stall held for 3 cycles at pc_f = 0x10 → pc_f stays 0x10. Release → 0x14. Repeat with div_stall and with cache_stall → same hold behaviour.
3. Training: upd_valid_e with upd_pc_e = 0x20, taken, target 0x80, once → counter becomes 10 (WT), BTB valid. Next fetch of 0x20 → bp_f = 1, next pc = 0x80. Then two not-taken updates → counter 00; fetch of 0x20 gives bp_f = 0, next pc = 0x24.
4. Saturation: five taken updates on 0x40 → counter 11. One not-taken → 10, still predicted taken.
5. Priority: redirect_e (redirect_pc_e = 0x100) together with stall → pc = 0x100. redirect_e together with cache_stall for 2 cycles → pc held for 2 cycles, becomes 0x100 on the release edge. A simultaneous update is deferred until the release edge.
6. Aliasing and reset: train 0x20 (taken → 0x80), then fetch 0x120 (same idx, different tag) → bp_f = 0 (BTB miss; the shared counter is WT). Assert rst mid-run → pc_f = RESET_PC; fetch of 0x20 gives bp_f = 0.
